// File: rtl/dmem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
//   Shared types and constants for the data-memory port arbiter.
//   - arb_state_e      : arbiter FSM state encoding (2 bits)
//   - SEL_R / SEL_W    : requester selection constants (read stage / write-back)
//   - starve_cnt_width : width of the saturating starvation counter
// -----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // request path live, nothing outstanding
    RD_WAIT  = 2'd1,  // read outstanding, response goes to the read stage
    WR_WAIT  = 2'd2,  // write outstanding, response acknowledged internally
    RD_DRAIN = 2'd3   // flushed read outstanding, response swallowed
  } arb_state_e;

  localparam logic SEL_R = 1'b0;
  localparam logic SEL_W = 1'b1;

  // Enough bits to hold the value starve_max itself.
  function automatic int starve_cnt_width(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/dmem_req_select.sv
// -----------------------------------------------------------------------------
// dmem_req_select
//   Combinational requester selection for the shared dcache port.
//   Ports:
//     rd_elig_i    - read request present and not being flushed
//     wr_valid_i   - write request present
//     starve_cnt_i - consecutive write grants taken while a read waited
//     hold_valid_i - previous cycle stalled a request on dmem_ready
//     hold_sel_i   - selection that stalled
//     sel_o        - SEL_R or SEL_W
// -----------------------------------------------------------------------------
module dmem_req_select
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNTW       = starve_cnt_width(STARVE_MAX)
) (
  input  logic            rd_elig_i,
  input  logic            wr_valid_i,
  input  logic [CNTW-1:0] starve_cnt_i,
  input  logic            hold_valid_i,
  input  logic            hold_sel_i,
  output logic            sel_o
);

  localparam logic [CNTW-1:0] STARVE_LIM = CNTW'(STARVE_MAX);

  always_comb begin
    // NOTE: assigning a default before any branch guarantees every path drives
    // sel_o, so no latch is inferred.
    sel_o = SEL_W;
    if (hold_valid_i && (hold_sel_i == SEL_W)) begin
      // A stalled write keeps the port until the dcache takes it.
      sel_o = SEL_W;
    end else if (hold_valid_i && (hold_sel_i == SEL_R) && rd_elig_i) begin
      // A stalled read keeps the port only while it is still eligible;
      // otherwise it falls through to normal arbitration.
      sel_o = SEL_R;
    end else if (rd_elig_i && (!wr_valid_i || (starve_cnt_i == STARVE_LIM))) begin
      // Writes normally win; the read wins when alone or when starved.
      sel_o = SEL_R;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares one dcache port between the memory-read stage (loads) and the
//   write-back stage (stores), with at most one transaction outstanding.
//   Ports:
//     clk, reset           - clock, synchronous active-high reset
//     flush                - pipeline flush; kills in-flight / pending reads
//     rmem_*               - read request in, read response out
//     wmem_*               - write request in, wmem_done completion pulse out
//     dmem_*               - request out to / response in from the dcache
// -----------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int DDATAW     = 64,
  parameter int DSIZEW     = 4,
  parameter int DADDRW     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  // read stage
  input  logic              rmem_valid,
  output logic              rmem_ready,
  input  logic [DADDRW-1:0] rmem_address,
  output logic              rmem_dp_valid,
  input  logic              rmem_dp_ready,
  output logic [DDATAW-1:0] rmem_dp_read_data,
  // write-back stage
  input  logic              wmem_valid,
  output logic              wmem_ready,
  input  logic [DADDRW-1:0] wmem_address,
  input  logic [DDATAW-1:0] wmem_wr_data,
  input  logic [DSIZEW-1:0] wmem_wr_size,
  output logic              wmem_done,
  // dcache
  output logic              dmem_valid,
  input  logic              dmem_ready,
  output logic [DADDRW-1:0] dmem_address,
  output logic              dmem_wr_en,
  output logic [DDATAW-1:0] dmem_wr_data,
  output logic [DSIZEW-1:0] dmem_wr_size,
  input  logic              dmem_dp_valid,
  output logic              dmem_dp_ready,
  input  logic [DDATAW-1:0] dmem_dp_read_data
);

  localparam int              CNTW       = starve_cnt_width(STARVE_MAX);
  localparam logic [CNTW-1:0] STARVE_LIM = CNTW'(STARVE_MAX);

  arb_state_e      state_q, state_d;
  logic [CNTW-1:0] starve_cnt_q, starve_cnt_d;
  logic            hold_q, hold_d;
  logic            hold_sel_q, hold_sel_d;

  logic            sel;
  logic            req_live;
  logic            rd_elig;
  logic            sel_valid;
  logic            rd_acc;
  logic            wr_acc;

  assign req_live = (state_q == IDLE);
  assign rd_elig  = rmem_valid & ~flush;

  dmem_req_select #(
    .STARVE_MAX (STARVE_MAX),
    .CNTW       (CNTW)
  ) u_req_select (
    .rd_elig_i    (rd_elig),
    .wr_valid_i   (wmem_valid),
    .starve_cnt_i (starve_cnt_q),
    .hold_valid_i (hold_q),
    .hold_sel_i   (hold_sel_q),
    .sel_o        (sel)
  );

  // Request path: only live in IDLE. Address/data are zeroed when nothing is
  // being presented so idle outputs are clean.
  always_comb begin
    sel_valid    = (sel == SEL_W) ? wmem_valid : rd_elig;
    dmem_valid   = req_live & sel_valid;
    dmem_wr_en   = dmem_valid & (sel == SEL_W);
    dmem_address = '0;
    if (dmem_valid) begin
      dmem_address = (sel == SEL_W) ? wmem_address : rmem_address;
    end
    dmem_wr_data = dmem_wr_en ? wmem_wr_data : '0;
    dmem_wr_size = dmem_wr_en ? wmem_wr_size : '0;
    rmem_ready   = req_live & (sel == SEL_R) & dmem_ready;
    wmem_ready   = req_live & (sel == SEL_W) & dmem_ready;
  end

  assign rd_acc = rmem_ready & rd_elig;
  assign wr_acc = wmem_ready & wmem_valid;

  // Starvation counter and grant-hold bookkeeping.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (rd_acc) begin
      starve_cnt_d = '0;
    end else if (wr_acc && rmem_valid && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNTW'(1);
    end
    hold_d     = dmem_valid & ~dmem_ready;
    hold_sel_d = sel;
  end

  // FSM next state and response-path outputs.
  always_comb begin
    state_d       = state_q;
    dmem_dp_ready = 1'b0;
    rmem_dp_valid = 1'b0;
    wmem_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_acc) begin
          state_d = RD_WAIT;
        end else if (wr_acc) begin
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        // On flush the response is swallowed here or, if not yet arrived,
        // later in RD_DRAIN.
        dmem_dp_ready = flush | rmem_dp_ready;
        rmem_dp_valid = dmem_dp_valid & ~flush;
        if (flush) begin
          state_d = dmem_dp_valid ? IDLE : RD_DRAIN;
        end else if (dmem_dp_valid && rmem_dp_ready) begin
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        dmem_dp_ready = 1'b1;
        wmem_done     = dmem_dp_valid;
        if (dmem_dp_valid) begin
          state_d = IDLE;
        end
      end
      RD_DRAIN: begin
        dmem_dp_ready = 1'b1;
        if (dmem_dp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rmem_dp_read_data = dmem_dp_read_data;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      hold_q       <= 1'b0;
      hold_sel_q   <= SEL_R;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      hold_q       <= hold_d;
      hold_sel_q   <= hold_sel_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter. Expected dcache requests, read
//   responses and write completions are queued by the stimulus; a monitor
//   pops and compares whenever the DUT presents one of them.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int DDATAW = 64;
  localparam int DSIZEW = 4;
  localparam int DADDRW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              rmem_valid;
  logic              rmem_ready;
  logic [DADDRW-1:0] rmem_address;
  logic              rmem_dp_valid;
  logic              rmem_dp_ready;
  logic [DDATAW-1:0] rmem_dp_read_data;
  logic              wmem_valid;
  logic              wmem_ready;
  logic [DADDRW-1:0] wmem_address;
  logic [DDATAW-1:0] wmem_wr_data;
  logic [DSIZEW-1:0] wmem_wr_size;
  logic              wmem_done;
  logic              dmem_valid;
  logic              dmem_ready;
  logic [DADDRW-1:0] dmem_address;
  logic              dmem_wr_en;
  logic [DDATAW-1:0] dmem_wr_data;
  logic [DSIZEW-1:0] dmem_wr_size;
  logic              dmem_dp_valid;
  logic              dmem_dp_ready;
  logic [DDATAW-1:0] dmem_dp_read_data;

  dmem_port_arbiter #(
    .DDATAW(DDATAW), .DSIZEW(DSIZEW), .DADDRW(DADDRW), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .rmem_valid(rmem_valid), .rmem_ready(rmem_ready), .rmem_address(rmem_address),
    .rmem_dp_valid(rmem_dp_valid), .rmem_dp_ready(rmem_dp_ready),
    .rmem_dp_read_data(rmem_dp_read_data),
    .wmem_valid(wmem_valid), .wmem_ready(wmem_ready), .wmem_address(wmem_address),
    .wmem_wr_data(wmem_wr_data), .wmem_wr_size(wmem_wr_size), .wmem_done(wmem_done),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_address(dmem_address),
    .dmem_wr_en(dmem_wr_en), .dmem_wr_data(dmem_wr_data), .dmem_wr_size(dmem_wr_size),
    .dmem_dp_valid(dmem_dp_valid), .dmem_dp_ready(dmem_dp_ready),
    .dmem_dp_read_data(dmem_dp_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              wr;
    logic [DADDRW-1:0] addr;
    logic [DDATAW-1:0] data;
    logic [DSIZEW-1:0] size;
  } grant_t;

  grant_t            exp_grant_q[$];
  logic [DDATAW-1:0] exp_rdata_q[$];
  bit                exp_done_q[$];

  int  n_checks = 0;
  int  n_errors = 0;
  bit  auto_resp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [63:0] d, input logic [3:0] s);
    grant_t g;
    g.wr = 1'b1; g.addr = a; g.data = d; g.size = s;
    exp_grant_q.push_back(g);
  endtask

  task automatic push_rd(input logic [31:0] a);
    grant_t g;
    g.wr = 1'b0; g.addr = a; g.data = '0; g.size = '0;
    exp_grant_q.push_back(g);
  endtask

  // Wait to mid-cycle, where outputs are stable.
  task automatic settle();
    @(negedge clk);
  endtask

  // Called at mid-cycle: advance one edge. With auto_resp set, the dcache
  // model answers one cycle after every accepted request.
  task automatic tick();
    logic              acc;
    logic [DADDRW-1:0] a;
    acc = dmem_valid && dmem_ready;
    a   = dmem_address;
    @(posedge clk);
    #1;
    if (auto_resp) begin
      dmem_dp_valid     = acc;
      dmem_dp_read_data = acc ? {32'hCAFE_0000, a} : '0;
    end
  endtask

  // Scoreboard monitor.
  initial begin
    grant_t g;
    forever begin
      @(negedge clk);
      if (!reset && dmem_valid && dmem_ready) begin
        check("grant_expected", 64'(exp_grant_q.size() != 0), 64'd1);
        if (exp_grant_q.size() != 0) begin
          g = exp_grant_q.pop_front();
          check("grant_wr_en", 64'(dmem_wr_en), 64'(g.wr));
          check("grant_addr", 64'(dmem_address), 64'(g.addr));
          check("grant_wr_data", dmem_wr_data, g.data);
          check("grant_wr_size", 64'(dmem_wr_size), 64'(g.size));
        end
      end
      if (!reset && rmem_dp_valid && rmem_dp_ready) begin
        check("rdata_expected", 64'(exp_rdata_q.size() != 0), 64'd1);
        if (exp_rdata_q.size() != 0) begin
          check("rdata_value", rmem_dp_read_data, exp_rdata_q.pop_front());
        end
      end
      if (!reset && wmem_done) begin
        check("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
        if (exp_done_q.size() != 0) void'(exp_done_q.pop_front());
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_outputs_idle(input string tag);
    check({tag, "_dmem_valid"}, 64'(dmem_valid), 64'd0);
    check({tag, "_dmem_wr_en"}, 64'(dmem_wr_en), 64'd0);
    check({tag, "_dmem_dp_ready"}, 64'(dmem_dp_ready), 64'd0);
    check({tag, "_rmem_ready"}, 64'(rmem_ready), 64'd0);
    check({tag, "_wmem_ready"}, 64'(wmem_ready), 64'd0);
    check({tag, "_rmem_dp_valid"}, 64'(rmem_dp_valid), 64'd0);
    check({tag, "_wmem_done"}, 64'(wmem_done), 64'd0);
    check({tag, "_dmem_address"}, 64'(dmem_address), 64'd0);
    check({tag, "_dmem_wr_data"}, dmem_wr_data, 64'd0);
    check({tag, "_dmem_wr_size"}, 64'(dmem_wr_size), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    rmem_valid = 1'b0; rmem_address = '0; rmem_dp_ready = 1'b0;
    wmem_valid = 1'b0; wmem_address = '0; wmem_wr_data = '0; wmem_wr_size = '0;
    dmem_ready = 1'b0; dmem_dp_valid = 1'b0; dmem_dp_read_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // ---------------- reset state ----------------
    settle();
    check("reset_state", 64'(dut.state_q), 64'(IDLE));
    check("reset_starve_cnt", 64'(dut.starve_cnt_q), 64'd0);
    check_outputs_idle("reset");
    tick();

    // ---------------- lone read ----------------
    rmem_valid = 1'b1; rmem_address = 32'h1000; dmem_ready = 1'b1;
    push_rd(32'h1000);
    settle();
    check("lone_rmem_ready", 64'(rmem_ready), 64'd1);
    tick();
    rmem_valid = 1'b0; dmem_ready = 1'b0; rmem_dp_ready = 1'b1;
    settle();
    check("lone_state_rd_wait", 64'(dut.state_q), 64'(RD_WAIT));
    check("lone_no_early_valid", 64'(rmem_dp_valid), 64'd0);
    check("lone_dp_ready", 64'(dmem_dp_ready), 64'd1);
    tick();
    dmem_dp_valid = 1'b1; dmem_dp_read_data = 64'hDEADBEEF;
    exp_rdata_q.push_back(64'hDEADBEEF);
    settle();
    check("lone_rmem_dp_valid", 64'(rmem_dp_valid), 64'd1);
    tick();
    dmem_dp_valid = 1'b0; dmem_dp_read_data = '0;
    settle();
    check("lone_back_idle", 64'(dut.state_q), 64'(IDLE));
    check("lone_dp_valid_drop", 64'(rmem_dp_valid), 64'd0);
    tick();

    // ---------------- starvation: W W W W R W ----------------
    auto_resp = 1'b1;
    rmem_valid = 1'b1; rmem_address = 32'h3000;
    wmem_valid = 1'b1; wmem_address = 32'h2000;
    wmem_wr_data = 64'h1111_2222_3333_4444; wmem_wr_size = 4'hF;
    dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_wr(32'h2000, 64'h1111_2222_3333_4444, 4'hF);
      exp_done_q.push_back(1'b1);
    end
    push_rd(32'h3000);
    exp_rdata_q.push_back(64'hCAFE_0000_0000_3000);
    push_wr(32'h2000, 64'h1111_2222_3333_4444, 4'hF);
    exp_done_q.push_back(1'b1);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 11) begin
        rmem_valid = 1'b0; wmem_valid = 1'b0;
      end
      settle();
      if (cyc == 8) begin
        check("starve_cnt_at_max", 64'(dut.starve_cnt_q), 64'd4);
        check("starve_read_wins", 64'(rmem_ready), 64'd1);
      end
      if (cyc == 10) begin
        check("starve_cnt_cleared", 64'(dut.starve_cnt_q), 64'd0);
        check("starve_write_again", 64'(wmem_ready), 64'd1);
      end
      tick();
    end

    // ---------------- hold: stalled write while read rises ----------------
    wmem_valid = 1'b1; wmem_address = 32'h4000; wmem_wr_data = 64'h55AA; wmem_wr_size = 4'h3;
    dmem_ready = 1'b0;
    settle();
    check("hold_w_first", 64'(dmem_wr_en), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      rmem_valid = 1'b1; rmem_address = 32'h4400;
      settle();
      check("hold_w_kept", 64'(dmem_wr_en), 64'd1);
      check("hold_w_addr", 64'(dmem_address), 64'h4000);
      check("hold_no_rready", 64'(rmem_ready), 64'd0);
      tick();
    end
    dmem_ready = 1'b1;
    push_wr(32'h4000, 64'h55AA, 4'h3);
    exp_done_q.push_back(1'b1);
    settle();
    check("hold_w_accept", 64'(wmem_ready), 64'd1);
    tick();
    wmem_valid = 1'b0; rmem_valid = 1'b0;
    settle(); tick();
    settle(); tick();

    // ---------------- hold: stalled read keeps port over new write ----------------
    rmem_valid = 1'b1; rmem_address = 32'h5000; dmem_ready = 1'b0;
    settle();
    check("rhold_first_addr", 64'(dmem_address), 64'h5000);
    tick();
    wmem_valid = 1'b1; wmem_address = 32'h6000; wmem_wr_data = 64'hA5A5; wmem_wr_size = 4'h1;
    settle();
    check("rhold_kept_wr_en", 64'(dmem_wr_en), 64'd0);
    check("rhold_kept_addr", 64'(dmem_address), 64'h5000);
    tick();
    dmem_ready = 1'b1;
    push_rd(32'h5000);
    exp_rdata_q.push_back(64'hCAFE_0000_0000_5000);
    push_wr(32'h6000, 64'hA5A5, 4'h1);
    exp_done_q.push_back(1'b1);
    settle();
    check("rhold_accept_r", 64'(rmem_ready), 64'd1);
    check("rhold_no_wready", 64'(wmem_ready), 64'd0);
    tick();
    rmem_valid = 1'b0;
    settle(); tick();                // RD_WAIT, response forwarded
    settle(); tick();                // IDLE, write 0x6000 accepted
    wmem_valid = 1'b0;
    settle(); tick();                // WR_WAIT, response
    settle(); tick();

    // ---------------- held read loses eligibility on flush ----------------
    rmem_valid = 1'b1; rmem_address = 32'h5100; dmem_ready = 1'b0;
    settle(); tick();
    flush = 1'b1;
    wmem_valid = 1'b1; wmem_address = 32'h6100; wmem_wr_data = 64'h77; wmem_wr_size = 4'h7;
    settle();
    check("rearb_wr_en", 64'(dmem_wr_en), 64'd1);
    check("rearb_addr", 64'(dmem_address), 64'h6100);
    tick();
    flush = 1'b0; rmem_valid = 1'b0; dmem_ready = 1'b1;
    push_wr(32'h6100, 64'h77, 4'h7);
    exp_done_q.push_back(1'b1);
    settle(); tick();
    wmem_valid = 1'b0;
    settle(); tick();
    settle(); tick();
    auto_resp = 1'b0;
    dmem_dp_valid = 1'b0; dmem_dp_read_data = '0;

    // ---------------- flush during RD_WAIT without response ----------------
    rmem_valid = 1'b1; rmem_address = 32'h7000; dmem_ready = 1'b1; rmem_dp_ready = 1'b0;
    push_rd(32'h7000);
    settle(); tick();
    rmem_valid = 1'b0; dmem_ready = 1'b0; flush = 1'b1;
    settle();
    check("fl_rdwait_dp_ready", 64'(dmem_dp_ready), 64'd1);
    check("fl_rdwait_no_valid", 64'(rmem_dp_valid), 64'd0);
    tick();
    flush = 1'b0;
    settle();
    check("fl_state_drain", 64'(dut.state_q), 64'(RD_DRAIN));
    check("fl_drain_dp_ready", 64'(dmem_dp_ready), 64'd1);
    tick();
    dmem_dp_valid = 1'b1; dmem_dp_read_data = 64'hBAD;
    settle();
    check("fl_drain_swallow", 64'(rmem_dp_valid), 64'd0);
    check("fl_drain_still", 64'(dut.state_q), 64'(RD_DRAIN));
    tick();
    dmem_dp_valid = 1'b0; dmem_dp_read_data = '0;
    settle();
    check("fl_drain_to_idle", 64'(dut.state_q), 64'(IDLE));
    tick();

    // ---------------- flush coincident with response ----------------
    rmem_valid = 1'b1; rmem_address = 32'h8000; dmem_ready = 1'b1;
    push_rd(32'h8000);
    settle(); tick();
    rmem_valid = 1'b0; dmem_ready = 1'b0;
    flush = 1'b1; dmem_dp_valid = 1'b1; dmem_dp_read_data = 64'h1234;
    settle();
    check("flc_no_rvalid", 64'(rmem_dp_valid), 64'd0);
    check("flc_dp_ready", 64'(dmem_dp_ready), 64'd1);
    tick();
    flush = 1'b0; dmem_dp_valid = 1'b0; dmem_dp_read_data = '0;
    settle();
    check("flc_to_idle", 64'(dut.state_q), 64'(IDLE));
    tick();

    // ---------------- flush during a write (grant and completion) ----------------
    flush = 1'b1; dmem_ready = 1'b1;
    wmem_valid = 1'b1; wmem_address = 32'h9000; wmem_wr_data = 64'h9999; wmem_wr_size = 4'h8;
    push_wr(32'h9000, 64'h9999, 4'h8);
    exp_done_q.push_back(1'b1);
    settle();
    check("flw_granted", 64'(wmem_ready), 64'd1);
    tick();
    wmem_valid = 1'b0; dmem_ready = 1'b0; dmem_dp_valid = 1'b1;
    settle();
    check("flw_done_pulse", 64'(wmem_done), 64'd1);
    tick();
    flush = 1'b0; dmem_dp_valid = 1'b0;
    settle();
    check("flw_done_one_cycle", 64'(wmem_done), 64'd0);
    check("flw_idle", 64'(dut.state_q), 64'(IDLE));
    tick();

    // ---------------- reset mid-transaction ----------------
    auto_resp = 1'b1;
    rmem_valid = 1'b1; rmem_address = 32'h3000;
    wmem_valid = 1'b1; wmem_address = 32'hA000; wmem_wr_data = 64'hAA; wmem_wr_size = 4'h2;
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_wr(32'hA000, 64'hAA, 4'h2);
      exp_done_q.push_back(1'b1);
    end
    push_wr(32'hA000, 64'hAA, 4'h2);   // abandoned by reset, never completes
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc == 6) rmem_valid = 1'b0;
      settle();
      if (cyc == 6) auto_resp = 1'b0;
      tick();
    end
    wmem_valid = 1'b0; dmem_ready = 1'b0; reset = 1'b1;
    settle();
    check("rst_pre_state", 64'(dut.state_q), 64'(WR_WAIT));
    check("rst_pre_cnt", 64'(dut.starve_cnt_q), 64'd3);
    tick();
    reset = 1'b0;
    settle();
    check("rst_state", 64'(dut.state_q), 64'(IDLE));
    check("rst_cnt", 64'(dut.starve_cnt_q), 64'd0);
    check_outputs_idle("rst");
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rst_no_done", 64'(wmem_done), 64'd0);
      tick();
    end

    // ---------------- leftovers ----------------
    settle();
    check("left_grants", 64'(exp_grant_q.size()), 64'd0);
    check("left_rdata", 64'(exp_rdata_q.size()), 64'd0);
    check("left_done", 64'(exp_done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
